// File: rtl/parity_arbiter_pkg.sv
// Shared definitions for the parity arbiter: sizes and FSM state encoding.
package parity_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/parity_arbiter_core.sv
// Shared combinational parity core: XOR of four single-bit inputs.
module parity4_core (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    assign y = a ^ b ^ c ^ d;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin front end that time-shares one parity core among four requesters.
// Each job: grant one requester, latch its nibble, wait CALC_CYC cycles for the
// core to settle, then hold the result on a valid/ready handshake.
module parity_arbiter
    import parity_arbiter_pkg::*;
#(
    parameter int CALC_CYC = 1,
    parameter bit PAR_ODD  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*NIB_W-1:0] data,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   res_valid,
    output logic                   res_parity,
    output logic [1:0]             res_id,
    input  logic                   res_ready
);

    state_t           state;
    logic [1:0]       ptr;
    logic [3:0]       cnt;
    logic [NIB_W-1:0] op;
    logic [1:0]       winner;
    logic             core_par;

    // First set request scanning ptr, ptr+1, ... (mod 4); the highest offset
    // is visited first so the lowest offset overwrites it and wins.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // Round-robin winner among the current requests
    always_comb winner = rr_pick(req, ptr);

    assign busy = (state != IDLE);

    parity4_core u_core (
        .a (op[0]),
        .b (op[1]),
        .c (op[2]),
        .d (op[3]),
        .y (core_par)
    );

    // Job sequencer: grant/capture in IDLE, settle in CALC, handshake in OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            res_valid  <= 1'b0;
            res_parity <= 1'b0;
            res_id     <= 2'd0;
            ptr        <= 2'd0;
            cnt        <= 4'd0;
            op         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= N_REQ'(1) << winner;
                        op     <= data[NIB_W*winner +: NIB_W];
                        res_id <= winner;
                        cnt    <= 4'(CALC_CYC - 1);
                        state  <= CALC;
                    end else begin
                        gnt <= '0;
                    end
                end
                CALC: begin
                    gnt <= '0;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_parity <= core_par ^ PAR_ODD;
                        res_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    // Pointer moves only on accept so the served requester drops to lowest priority
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= res_id + 2'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_arbiter.sv
// Bench for parity_arbiter: three instances (default, slow CALC_CYC=4, odd
// parity) share stimulus; a job-level model is compared every cycle, and
// directed scenarios add hand-computed expectations.
module tb_parity_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] data = 16'd0;
    logic        ready = 1'b1;

    logic [3:0]  gnt_o   [3];
    logic        busy_o  [3];
    logic        valid_o [3];
    logic        par_o   [3];
    logic [1:0]  id_o    [3];

    int checks = 0;
    int failures = 0;
    bit seeded = 1'b0;

    always #5 clk = ~clk;

    parity_arbiter #(.CALC_CYC(1), .PAR_ODD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt_o[0]), .busy(busy_o[0]),
        .res_valid(valid_o[0]), .res_parity(par_o[0]), .res_id(id_o[0]), .res_ready(ready));
    parity_arbiter #(.CALC_CYC(4), .PAR_ODD(1'b0)) u_slow (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt_o[1]), .busy(busy_o[1]),
        .res_valid(valid_o[1]), .res_parity(par_o[1]), .res_id(id_o[1]), .res_ready(ready));
    parity_arbiter #(.CALC_CYC(1), .PAR_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt_o[2]), .busy(busy_o[2]),
        .res_valid(valid_o[2]), .res_parity(par_o[2]), .res_id(id_o[2]), .res_ready(ready));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- job-level model ----------------
    typedef struct {
        bit         job;   // a job is in flight (granted, not yet accepted)
        int         age;   // cycles since the grant edge
        int         id;
        logic [3:0] nib;
        bit         vld;
        bit         par;
        int         ptr;
    } mdl_t;

    mdl_t m [3];
    int   calc_cyc [3] = '{1, 4, 1};
    bit   odd      [3] = '{1'b0, 1'b0, 1'b1};

    always @(posedge clk) begin
        mdl_t t;
        int w;
        for (int i = 0; i < 3; i++) begin
            t = m[i];
            if (rst) begin
                t = '{job: 1'b0, age: 0, id: 0, nib: 4'h0, vld: 1'b0, par: 1'b0, ptr: 0};
            end else if (!t.job) begin
                if (req != 4'd0) begin
                    w = 0;
                    for (int k = 3; k >= 0; k--)
                        if (req[(t.ptr + k) % 4]) w = (t.ptr + k) % 4;
                    t.job = 1'b1;
                    t.age = 0;
                    t.id  = w;
                    t.nib = data[4*w +: 4];
                end
            end else if (t.vld) begin
                if (ready) begin
                    t.vld = 1'b0;
                    t.job = 1'b0;
                    t.ptr = (t.id + 1) % 4;
                end
            end else begin
                t.age = t.age + 1;
                if (t.age == calc_cyc[i]) begin
                    t.vld = 1'b1;
                    t.par = (($countones(t.nib) % 2) == 1) ^ odd[i];
                end
            end
            m[i] <= t;
        end
        if (rst) seeded <= 1'b1;
    end

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        if (seeded) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("m%0d_gnt", i), 32'(gnt_o[i]),
                    (m[i].job && m[i].age == 0) ? 32'(4'b0001 << m[i].id) : 32'd0);
                chk($sformatf("m%0d_busy", i), 32'(busy_o[i]), 32'(m[i].job));
                chk($sformatf("m%0d_valid", i), 32'(valid_o[i]), 32'(m[i].vld));
                chk($sformatf("m%0d_par", i), 32'(par_o[i]), 32'(m[i].par));
                chk($sformatf("m%0d_id", i), 32'(id_o[i]), 32'(m[i].id));
                chk($sformatf("m%0d_onehot", i), 32'($countones(gnt_o[i]) <= 1), 32'd1);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy_o[0] | busy_o[1] | busy_o[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_o[0] | busy_o[1] | busy_o[2]) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // which: 0 = wait for any grant, 1 = wait for res_valid
    task automatic wait_sig(input int which, input int inst);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? (gnt_o[inst] != 4'd0) : valid_o[inst];
        end
        if (!hit) chk($sformatf("wait%0d_inst%0d_timeout", which, inst), 32'd1, 32'd0);
    endtask

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int got [5];
        int cnt;
        int n;
        logic [15:0] par_tab;
        logic [1:0]  hold_id;
        logic        hold_par;

        // Reset state
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_gnt%0d", i), 32'(gnt_o[i]), 32'd0);
            chk($sformatf("rst_valid%0d", i), 32'(valid_o[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 32'd0);
        end

        // 1: single request, nibble 1011
        req = 4'b0001;
        data = 16'h000B;
        ready = 1'b1;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt_o[0]), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_valid", 32'(valid_o[0]), 32'd1);
        chk("t1_par", 32'(par_o[0]), 32'd1);
        chk("t1_id", 32'(id_o[0]), 32'd0);
        chk("t1_gnt_low", 32'(gnt_o[0]), 32'd0);
        wait_idle();

        // 2: round robin with all four requesting
        do_reset();
        req = 4'b1111;
        data = 16'h0000;
        cnt = 0;
        n = 0;
        while (cnt < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (valid_o[0] && ready) begin
                got[cnt] = int'(id_o[0]);
                cnt++;
            end
        end
        if (cnt < 5) chk("t2_timeout", 32'd1, 32'd0);
        for (int j = 0; j < cnt; j++) chk($sformatf("t2_seq%0d", j), 32'(got[j]), 32'(exp_seq[j]));
        req = 4'b0000;
        wait_idle();

        // 3: backpressure
        do_reset();
        req = 4'b1111;
        data = 16'h7000;
        ready = 1'b0;
        wait_sig(1, 0);
        hold_id = id_o[0];
        hold_par = par_o[0];
        chk("t3_id0", 32'(hold_id), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_valid", 32'(valid_o[0]), 32'd1);
            chk("t3_par", 32'(par_o[0]), 32'(hold_par));
            chk("t3_id", 32'(id_o[0]), 32'd0);
            chk("t3_gnt", 32'(gnt_o[0]), 32'd0);
            chk("t3_busy", 32'(busy_o[0]), 32'd1);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("t3_accepted", 32'(valid_o[0]), 32'd0);
        @(negedge clk);
        chk("t3_next_gnt", 32'(gnt_o[0]), 32'h2);
        req = 4'b0000;
        wait_idle();

        // 4: sweep requester 2 over all nibbles; data disturbed after capture
        do_reset();
        par_tab = 16'h6996;
        for (int v = 0; v < 16; v++) begin
            data = 16'(v) << 8;
            req = 4'b0100;
            wait_sig(0, 0);
            chk("t4_gnt", 32'(gnt_o[0]), 32'h4);
            req = 4'b0000;
            data = 16'(~v & 15) << 8;
            wait_sig(1, 0);
            chk($sformatf("t4_par_%0d", v), 32'(par_o[0]), 32'(par_tab[v]));
            chk("t4_id", 32'(id_o[0]), 32'd2);
            wait_idle();
        end

        // 5: reset during the second CALC cycle of the slow instance
        do_reset();
        req = 4'b0010;
        data = 16'h00F0;
        wait_sig(0, 1);
        req = 4'b0000;
        @(negedge clk);
        chk("t5_in_calc", 32'(busy_o[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_gnt", 32'(gnt_o[1]), 32'd0);
        chk("t5_busy", 32'(busy_o[1]), 32'd0);
        chk("t5_valid", 32'(valid_o[1]), 32'd0);
        chk("t5_par", 32'(par_o[1]), 32'd0);
        chk("t5_id", 32'(id_o[1]), 32'd0);
        req = 4'b1111;
        wait_sig(0, 1);
        chk("t5_regrant", 32'(gnt_o[1]), 32'h1);
        req = 4'b0000;
        wait_idle();

        // 6: odd parity instance, requester 3, nibble 0000
        do_reset();
        req = 4'b1000;
        data = 16'h0000;
        wait_sig(1, 2);
        chk("t6_odd_par", 32'(par_o[2]), 32'd1);
        chk("t6_odd_id", 32'(id_o[2]), 32'd3);
        chk("t6_even_par", 32'(par_o[0]), 32'd0);
        req = 4'b0000;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
